phase_sequencer: RTL

- Multi-cycle instruction sequencer for the 16-bit processor core.
- Steps each instruction through fetch, decode, execute, memory and writeback phases, driven by the 6-bit major opcode in the instruction register.
- Generates the one-cycle enable pulse that latches the ALU control decode, plus the memory, register-file, flag and PC strobes.
- Sits between the instruction register, the memory wait/ready interface and the datapath enables.

---
 rtl/phase_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// Multi-cycle instruction phase sequencer: steps each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath strobes.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_HALT   | idle, waiting for run; entered on reset, HALT op or timeout
// S_FETCH  | instruction read in flight, ir_e when mem_ready
// S_DECODE | opcode classified, ALU control decode latched
// S_EXEC   | ALU result valid; branches, CMP retire here
// S_MEM    | data load/store in flight, waiting for mem_ready
// S_WB     | register file write and retirement
module phase_sequencer #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       ir_op,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             fetch_e,
  output logic             ir_e,
  output logic             alu_control_unit_e,
  output logic             flag_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic             reg_we,
  output logic             pc_e,
  output logic             pc_br_sel,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] retire_cnt
);

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_HALT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

  logic op_mem, op_load, op_br, op_hlt, op_cmp, op_alu, timeout;

  assign op_mem  = ~ir_op[5];
  assign op_load = (ir_op[5:4] == 2'b00);
  assign op_br   = (ir_op[5:1] == 5'b10111);
  assign op_hlt  = (ir_op == 6'b101100);
  assign op_cmp  = (ir_op == 6'b110101);
  assign op_alu  = (ir_op[5:4] == 2'b11);
  assign timeout = TIMEOUT_EN && !mem_ready && (wait_q == WAIT_LAST);

  always_comb begin
    state_d            = state_q;
    bus_err_d          = bus_err_q;
    fetch_e            = 1'b0;
    ir_e               = 1'b0;
    alu_control_unit_e = 1'b0;
    flag_we            = 1'b0;
    mem_re             = 1'b0;
    mem_we             = 1'b0;
    reg_we             = 1'b0;
    pc_e               = 1'b0;
    pc_br_sel          = 1'b0;
    halted             = 1'b0;
    case (state_q)
      S_HALT: begin
        halted = 1'b1;
        if (run) begin
          state_d   = S_FETCH;
          bus_err_d = 1'b0;
        end
      end
      S_FETCH: begin
        fetch_e = 1'b1;
        if (mem_ready) begin
          ir_e    = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        alu_control_unit_e = op_mem | op_br | op_alu;
        if (op_hlt) begin
          pc_e    = 1'b1;
          state_d = S_HALT;
        end else if (!op_mem && !op_br && !op_alu) begin
          pc_e    = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_mem) begin
          state_d = S_MEM;
        end else if (op_br) begin
          pc_e      = 1'b1;
          pc_br_sel = br_taken;
          state_d   = S_FETCH;
        end else if (op_cmp) begin
          flag_we = 1'b1;
          pc_e    = 1'b1;
          state_d = S_FETCH;
        end else if (op_alu) begin
          flag_we = 1'b1;
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        mem_re = op_load;
        mem_we = ~op_load;
        if (mem_ready) begin
          // Stores retire on completion; loads still need writeback.
          pc_e    = ~op_load;
          state_d = op_load ? S_WB : S_FETCH;
        end else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_e    = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase

    if (state_d != state_q)
      wait_d = '0;
    else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready)
      wait_d = wait_q + 1'b1;
    else
      wait_d = wait_q;

    retire_cnt_d = retire_cnt_q + CNT_W'(pc_e);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_HALT;
      wait_q       <= '0;
      bus_err_q    <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      bus_err_q    <= bus_err_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign bus_err    = bus_err_q;
  assign retire_cnt = retire_cnt_q;

endmodule
